// File: rtl/txn_receive_checker.sv
// Device-side sink for a random USB transaction stream: LFSR-paced backpressure,
// phase-order checking, saturating per-type counters and first-error capture.
module txn_receive_checker #(
  parameter int          N_SETUP     = 5,
  parameter int          N_OUT       = 5,
  parameter int          N_IN        = 5,
  parameter int          CNT_W       = 32,
  parameter int          READY_LOG2  = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [6:0]  EXP_ADDR    = 7'd0,
  parameter logic [3:0]  EXP_ENDP    = 4'd0,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_txnType,
  input  logic [6:0]       i_txnAddr,
  input  logic [3:0]       i_txnEndp,
  output logic [CNT_W-1:0] o_nTxns,
  output logic [CNT_W-1:0] o_nSetup,
  output logic [CNT_W-1:0] o_nOut,
  output logic [CNT_W-1:0] o_nIn,
  output logic [2:0]       o_phase,
  output logic             o_err,
  output logic [1:0]       o_errCode,
  output logic [CNT_W-1:0] o_errIdx
);

  typedef enum logic [1:0] {PH_SETUP, PH_OUT, PH_IN, PH_RANDOM} phase_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A phase whose required count is zero is passed straight through.
  function automatic phase_t skip_empty(input phase_t p);
    phase_t r;
    r = p;
    if (r == PH_SETUP && N_SETUP == 0) r = PH_OUT;
    if (r == PH_OUT && N_OUT == 0) r = PH_IN;
    if (r == PH_IN && N_IN == 0) r = PH_RANDOM;
    return r;
  endfunction

  function automatic logic [2:0] phase_bits(input phase_t p);
    case (p)
      PH_SETUP: return 3'b100;
      PH_OUT:   return 3'b010;
      PH_IN:    return 3'b001;
      default:  return 3'b111;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic reached(input logic [CNT_W-1:0] cnt, input int n);
    return 64'(cnt) >= 64'(n);
  endfunction

  logic [15:0]      lfsr_reg, lfsr_next;
  logic             ready_reg, ready_raw, ready_next;
  logic             accept, type_onehot, type_ok_for_phase, addr_ok;
  logic [1:0]       txn_err_code;
  logic             err_reg, err_next, new_err;
  logic [1:0]       err_code_reg;
  logic [CNT_W-1:0] err_idx_reg, ntxns_reg;
  logic [CNT_W-1:0] type_cnt      [3];
  logic [CNT_W-1:0] type_cnt_next [3];
  phase_t           phase_reg, phase_next;
  logic [2:0]       phase_bits_reg;

  always_comb begin
    lfsr_next         = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    accept            = i_valid && ready_reg;
    type_onehot       = $onehot(i_txnType);
    type_ok_for_phase = (phase_reg == PH_RANDOM) || (i_txnType == phase_bits(phase_reg));
    addr_ok           = (i_txnAddr == EXP_ADDR) && (i_txnEndp == EXP_ENDP);
    txn_err_code      = 2'd0;
    if (!type_onehot)            txn_err_code = 2'd1;
    else if (!type_ok_for_phase) txn_err_code = 2'd2;
    else if (!addr_ok)           txn_err_code = 2'd3;
    new_err    = accept && !err_reg && (txn_err_code != 2'd0);
    err_next   = err_reg || new_err;
    // Using the next error state keeps the sink closed from the very cycle o_err rises.
    ready_next = ready_raw && !(STOP_ON_ERR && err_next);
    phase_next = phase_reg;
    if (accept) begin
      case (phase_reg)
        PH_SETUP: if (reached(type_cnt_next[2], N_SETUP)) phase_next = skip_empty(PH_OUT);
        PH_OUT:   if (reached(type_cnt_next[1], N_OUT))   phase_next = skip_empty(PH_IN);
        PH_IN:    if (reached(type_cnt_next[0], N_IN))    phase_next = PH_RANDOM;
        default:  phase_next = PH_RANDOM;
      endcase
    end
  end

  generate
    if (READY_LOG2 == 0) begin : g_always_ready
      assign ready_raw = 1'b1;
    end else begin : g_lfsr_ready
      assign ready_raw = (lfsr_next[READY_LOG2-1:0] == '0);
    end
  endgenerate

  // Per-type counters; index follows the bit position in i_txnType (2=SETUP, 1=OUT, 0=IN).
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_type_cnt
      logic [CNT_W-1:0] cnt_reg;
      assign type_cnt_next[gi] = (accept && type_onehot && i_txnType[gi]) ? sat_inc(cnt_reg) : cnt_reg;
      assign type_cnt[gi]      = cnt_reg;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_reg <= '0;
        else          cnt_reg <= type_cnt_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_reg       <= LFSR_SEED;
      ready_reg      <= 1'b0;
      ntxns_reg      <= '0;
      err_reg        <= 1'b0;
      err_code_reg   <= 2'd0;
      err_idx_reg    <= '0;
      phase_reg      <= skip_empty(PH_SETUP);
      phase_bits_reg <= phase_bits(skip_empty(PH_SETUP));
    end else begin
      lfsr_reg       <= lfsr_next;
      ready_reg      <= ready_next;
      err_reg        <= err_next;
      phase_reg      <= phase_next;
      phase_bits_reg <= phase_bits(phase_next);
      if (accept) ntxns_reg <= sat_inc(ntxns_reg);
      if (new_err) begin
        err_code_reg <= txn_err_code;
        err_idx_reg  <= ntxns_reg;
      end
    end
  end

  assign o_ready   = ready_reg;
  assign o_nTxns   = ntxns_reg;
  assign o_nSetup  = type_cnt[2];
  assign o_nOut    = type_cnt[1];
  assign o_nIn     = type_cnt[0];
  assign o_phase   = phase_bits_reg;
  assign o_err     = err_reg;
  assign o_errCode = err_code_reg;
  assign o_errIdx  = err_idx_reg;

endmodule

// File: tb/tb_txn_receive_checker.sv
// Randomized self-checking bench for txn_receive_checker against a behavioural model.
module tb_txn_receive_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n = 1'b0, rst2_n = 1'b0, rst4_n = 1'b0;
  logic v0 = 1'b0, v2 = 1'b0, v4 = 1'b0;
  logic [2:0] typ = 3'b000;
  logic [6:0] addr = 7'd0;
  logic [3:0] endp = 4'd0;

  logic r0, err0; logic [2:0] ph0; logic [1:0] code0;
  logic [31:0] ntx0, set0, out0, in0, idx0;
  logic r2, err2; logic [2:0] ph2; logic [1:0] code2;
  logic [31:0] ntx2, set2, out2, in2, idx2;
  logic r4, err4; logic [2:0] ph4; logic [1:0] code4;
  logic [3:0] ntx4, set4, out4, in4, idx4;

  txn_receive_checker #(.READY_LOG2(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst0_n), .i_valid(v0), .o_ready(r0),
    .i_txnType(typ), .i_txnAddr(addr), .i_txnEndp(endp),
    .o_nTxns(ntx0), .o_nSetup(set0), .o_nOut(out0), .o_nIn(in0),
    .o_phase(ph0), .o_err(err0), .o_errCode(code0), .o_errIdx(idx0));

  txn_receive_checker #(.READY_LOG2(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .i_valid(v2), .o_ready(r2),
    .i_txnType(typ), .i_txnAddr(addr), .i_txnEndp(endp),
    .o_nTxns(ntx2), .o_nSetup(set2), .o_nOut(out2), .o_nIn(in2),
    .o_phase(ph2), .o_err(err2), .o_errCode(code2), .o_errIdx(idx2));

  txn_receive_checker #(.READY_LOG2(0), .CNT_W(4), .STOP_ON_ERR(1'b0)) dut4 (
    .i_clk(clk), .i_rst_n(rst4_n), .i_valid(v4), .o_ready(r4),
    .i_txnType(typ), .i_txnAddr(addr), .i_txnEndp(endp),
    .o_nTxns(ntx4), .o_nSetup(set4), .o_nOut(out4), .o_nIn(in4),
    .o_phase(ph4), .o_err(err4), .o_errCode(code4), .o_errIdx(idx4));

  int n_tests = 0;
  int n_fail  = 0;
  bit verbose = 1'b1;

  // Behavioural reference: phase index 0..3 = SETUP, OUT, IN, RANDOM.
  int unsigned m_ntx, m_set, m_out, m_in, m_max, m_idx;
  int          m_ph, m_code;
  bit          m_err;

  function automatic logic [2:0] ph_bits(input int p);
    case (p)
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  function automatic int unsigned sat(input int unsigned v);
    return (v >= m_max) ? v : v + 1;
  endfunction

  function automatic void m_reset(input int unsigned mx);
    m_ntx = 0; m_set = 0; m_out = 0; m_in = 0; m_idx = 0;
    m_ph = 0; m_code = 0; m_err = 1'b0; m_max = mx;
  endfunction

  function automatic void m_accept(input logic [2:0] t, input logic [6:0] a, input logic [3:0] e);
    int code;
    code = 0;
    if (!(t == 3'b001 || t == 3'b010 || t == 3'b100)) code = 1;
    else if (m_ph != 3 && t != ph_bits(m_ph))          code = 2;
    else if (a != 7'd0 || e != 4'd0)                   code = 3;
    if (code != 0 && !m_err) begin
      m_err = 1'b1; m_code = code; m_idx = m_ntx;
    end
    m_ntx = sat(m_ntx);
    if (t == 3'b100) m_set = sat(m_set);
    if (t == 3'b010) m_out = sat(m_out);
    if (t == 3'b001) m_in  = sat(m_in);
    if      (m_ph == 0 && m_set >= 5) m_ph = 1;
    else if (m_ph == 1 && m_out >= 5) m_ph = 2;
    else if (m_ph == 2 && m_in  >= 5) m_ph = 3;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic drive(input int sel, input bit v, input logic [2:0] t,
                       input logic [6:0] a, input logic [3:0] e);
    v0 = (sel == 0) && v; v2 = (sel == 2) && v; v4 = (sel == 4) && v;
    typ = t; addr = a; endp = e;
    if (verbose && v) $display("[TB] dut%0d txn type=%b addr=%0d endp=%0d", sel, t, a, e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int sel);
    v0 = 1'b0; v2 = 1'b0; v4 = 1'b0;
    if (sel == 0) rst0_n = 1'b0;
    if (sel == 2) rst2_n = 1'b0;
    if (sel == 4) rst4_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (sel == 0) rst0_n = 1'b1;
    if (sel == 2) rst2_n = 1'b1;
    if (sel == 4) rst4_n = 1'b1;
    m_reset((sel == 4) ? 32'd15 : 32'hFFFF_FFFF);
  endtask

  task automatic test_reset();
    do_reset(0);
    n_tests++;
    if (r0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", r0); end
    n_tests++;
    if ({ntx0, set0, out0, in0} !== 128'd0) begin
      n_fail++; $display("FAIL reset_counts got %0d/%0d/%0d/%0d want 0", ntx0, set0, out0, in0);
    end
    n_tests++;
    if (ph0 !== 3'b100) begin n_fail++; $display("FAIL reset_phase got %b want 100", ph0); end
    n_tests++;
    if ({err0, code0, idx0} !== 35'd0) begin
      n_fail++; $display("FAIL reset_err got err=%b code=%0d idx=%0d want 0", err0, code0, idx0);
    end
  endtask

  task automatic test_phase_order();
    logic [2:0] t;
    drive(0, 1'b0, 3'b000, 7'd0, 4'd0);
    for (int i = 0; i < 15; i++) begin
      t = (i < 5) ? 3'b100 : (i < 10) ? 3'b010 : 3'b001;
      n_tests++;
      if (r0 !== 1'b1) begin n_fail++; $display("FAIL order_ready[%0d] got %b want 1", i, r0); end
      drive(0, 1'b1, t, 7'd0, 4'd0);
      m_accept(t, 7'd0, 4'd0);
      n_tests++;
      if (ph0 !== ph_bits(m_ph)) begin
        n_fail++; $display("FAIL order_phase[%0d] got %b want %b", i, ph0, ph_bits(m_ph));
      end
    end
    n_tests++;
    if (ph0 !== 3'b111) begin n_fail++; $display("FAIL order_final_phase got %b want 111", ph0); end
    n_tests++;
    if (ntx0 !== 32'd15 || set0 !== 32'd5 || out0 !== 32'd5 || in0 !== 32'd5 || err0 !== 1'b0) begin
      n_fail++; $display("FAIL order_counts got %0d %0d/%0d/%0d err=%b want 15 5/5/5 err=0",
                         ntx0, set0, out0, in0, err0);
    end
  endtask

  task automatic test_random_mix();
    logic [2:0] t;
    bit v;
    int bad;
    bad = 0;
    verbose = 1'b0;
    while (m_ntx < 315) begin
      t = 3'(1 << $urandom_range(0, 2));
      v = ($urandom_range(0, 3) != 0);
      drive(0, v, t, 7'd0, 4'd0);
      if (v) m_accept(t, 7'd0, 4'd0);
      if (ntx0 !== m_ntx || set0 !== m_set || out0 !== m_out || in0 !== m_in) bad++;
    end
    verbose = 1'b1;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL random_track got %0d bad cycles want 0", bad); end
    n_tests++;
    if (ntx0 !== 32'd315 || set0 + out0 + in0 !== 32'd315) begin
      n_fail++; $display("FAIL random_sum got total=%0d sum=%0d want 315", ntx0, set0 + out0 + in0);
    end
    n_tests++;
    if (err0 !== 1'b0 || r0 !== 1'b1) begin
      n_fail++; $display("FAIL random_err got err=%b ready=%b want 0/1", err0, r0);
    end
  endtask

  task automatic test_wrong_phase();
    logic [2:0] seq [3];
    seq[0] = 3'b100; seq[1] = 3'b100; seq[2] = 3'b010;
    do_reset(0);
    drive(0, 1'b0, 3'b000, 7'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, seq[i], 7'd0, 4'd0);
      m_accept(seq[i], 7'd0, 4'd0);
    end
    n_tests++;
    if (err0 !== 1'b1 || code0 !== 2'(m_code) || idx0 !== m_idx || code0 !== 2'd2 || idx0 !== 32'd2) begin
      n_fail++; $display("FAIL wrong_phase_err got err=%b code=%0d idx=%0d want 1/2/2", err0, code0, idx0);
    end
    n_tests++;
    if (r0 !== 1'b0) begin n_fail++; $display("FAIL wrong_phase_ready got %b want 0", r0); end
    for (int i = 0; i < 4; i++) drive(0, 1'b1, 3'b100, 7'd0, 4'd0);
    n_tests++;
    if (r0 !== 1'b0 || ntx0 !== 32'd3 || set0 !== 32'd2) begin
      n_fail++; $display("FAIL wrong_phase_hold got ready=%b ntx=%0d set=%0d want 0/3/2", r0, ntx0, set0);
    end
  endtask

  task automatic test_not_onehot();
    do_reset(0);
    drive(0, 1'b0, 3'b000, 7'd0, 4'd0);
    drive(0, 1'b1, 3'b011, 7'd0, 4'd0);
    m_accept(3'b011, 7'd0, 4'd0);
    n_tests++;
    if (err0 !== 1'b1 || code0 !== 2'd1 || idx0 !== 32'd0) begin
      n_fail++; $display("FAIL onehot_err got err=%b code=%0d idx=%0d want 1/1/0", err0, code0, idx0);
    end
    n_tests++;
    if (ntx0 !== m_ntx || set0 !== 32'd0 || out0 !== 32'd0 || in0 !== 32'd0) begin
      n_fail++; $display("FAIL onehot_counts got ntx=%0d set=%0d want %0d/0", ntx0, set0, m_ntx);
    end
  endtask

  task automatic test_addr_saturate();
    logic [2:0] t;
    logic [6:0] a;
    int bad;
    bad = 0;
    do_reset(4);
    drive(4, 1'b0, 3'b000, 7'd0, 4'd0);
    drive(4, 1'b1, 3'b100, 7'd5, 4'd0);
    m_accept(3'b100, 7'd5, 4'd0);
    n_tests++;
    if (err4 !== 1'b1 || code4 !== 2'd3 || idx4 !== 4'd0) begin
      n_fail++; $display("FAIL addr_err got err=%b code=%0d idx=%0d want 1/3/0", err4, code4, idx4);
    end
    for (int i = 0; i < 19; i++) begin
      t = 3'($urandom_range(0, 7));
      a = 7'($urandom_range(0, 3));
      drive(4, 1'b1, t, a, 4'd0);
      m_accept(t, a, 4'd0);
      if (r4 !== 1'b1 || ntx4 !== 4'(m_ntx) || set4 !== 4'(m_set) || out4 !== 4'(m_out) ||
          in4 !== 4'(m_in) || ph4 !== ph_bits(m_ph)) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL sat_track got %0d bad cycles want 0", bad); end
    n_tests++;
    if (ntx4 !== 4'd15) begin n_fail++; $display("FAIL sat_total got %0d want 15", ntx4); end
    n_tests++;
    if (code4 !== 2'd3 || idx4 !== 4'd0 || err4 !== 1'b1) begin
      n_fail++; $display("FAIL addr_sticky got code=%0d idx=%0d err=%b want 3/0/1", code4, idx4, err4);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] lfsr;
    logic [2:0]  t;
    bit exp_rdy, prev;
    int bad_r, bad_n;
    bad_r = 0; bad_n = 0;
    do_reset(2);
    lfsr = 16'hACE1; exp_rdy = 1'b0;
    verbose = 1'b0;
    for (int c = 0; c < 4096; c++) begin
      prev = exp_rdy;
      t = (m_ph == 3) ? 3'(1 << $urandom_range(0, 2)) : ph_bits(m_ph);
      drive(2, 1'b1, t, 7'd0, 4'd0);
      if (prev) m_accept(t, 7'd0, 4'd0);
      lfsr = lfsr_step(lfsr);
      exp_rdy = (lfsr[1:0] == 2'b00) && !m_err;
      if (r2 !== exp_rdy) bad_r++;
      if (ntx2 !== m_ntx) bad_n++;
    end
    n_tests++;
    if (bad_r != 0) begin n_fail++; $display("FAIL bp_ready_seq got %0d bad cycles want 0", bad_r); end
    n_tests++;
    if (bad_n != 0) begin n_fail++; $display("FAIL bp_count_track got %0d bad cycles want 0", bad_n); end
    n_tests++;
    if (ntx2 < 32'd900 || ntx2 > 32'd1150) begin
      n_fail++; $display("FAIL bp_duty got %0d accepts want 900..1150", ntx2);
    end
    n_tests++;
    if (err2 !== 1'b0 || ph2 !== 3'b111) begin
      n_fail++; $display("FAIL bp_state got err=%b phase=%b want 0/111", err2, ph2);
    end
    for (int c = 0; c < 37; c++) drive(2, 1'b1, 3'b001, 7'd0, 4'd0);
    #1 rst2_n = 1'b0;
    #1;
    n_tests++;
    if (r2 !== 1'b0 || {ntx2, set2, out2, in2} !== 128'd0 || ph2 !== 3'b100 ||
        {err2, code2, idx2} !== 35'd0) begin
      n_fail++; $display("FAIL midrun_reset got ready=%b ntx=%0d phase=%b err=%b want 0/0/100/0",
                         r2, ntx2, ph2, err2);
    end
    @(negedge clk);
    rst2_n = 1'b1;
    m_reset(32'hFFFF_FFFF);
    lfsr = 16'hACE1; exp_rdy = 1'b0; bad_r = 0;
    for (int c = 0; c < 16; c++) begin
      prev = exp_rdy;
      drive(2, 1'b0, 3'b100, 7'd0, 4'd0);
      lfsr = lfsr_step(lfsr);
      exp_rdy = (lfsr[1:0] == 2'b00);
      if (r2 !== exp_rdy || ntx2 !== 32'd0) bad_r++;
    end
    verbose = 1'b1;
    n_tests++;
    if (bad_r != 0) begin n_fail++; $display("FAIL post_reset_seq got %0d bad cycles want 0", bad_r); end
  endtask

  initial begin
    test_reset();
    test_phase_order();
    test_random_mix();
    test_wrong_phase();
    test_not_onehot();
    test_addr_saturate();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish want finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
